wrr_arb_ack: RTL and testbench

- Weighted round-robin arbiter with a grant/acknowledge handshake.
- Shares one downstream resource (bus port, FIFO write port, memory bank) among CLIENTS requesters.
- Each client receives up to weight_cfg consecutive acknowledged grants per round before priority rotates past it.
- Grants are registered and held stable until acknowledged or withdrawn.

---
 rtl/wrr_arb_ack.sv | 144 ++++++++++++++
 tb/tb_wrr_arb_ack.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arb_ack.sv
// Weighted round-robin arbiter with a registered grant and an acknowledge
// handshake. Each requester gets up to max(weight,1) acknowledged grants per
// round before priority rotates past it. A grant is held until it is
// acknowledged or its request is withdrawn.
module wrr_arb_ack #(
    parameter int  CLIENTS  = 4,
    parameter int  WEIGHT_W = 4,
    localparam int ID_W     = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CLIENTS-1:0]          req,
    input  logic [CLIENTS*WEIGHT_W-1:0] weight_cfg,
    input  logic                        grant_ack,
    output logic [CLIENTS-1:0]          grant,
    output logic                        grant_valid,
    output logic [ID_W-1:0]             grant_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] credit_q [CLIENTS];
    logic [WEIGHT_W-1:0] credit_d [CLIENTS];
    logic [CLIENTS-1:0]  grant_d;
    logic [ID_W-1:0]     grant_id_d;
    logic [CLIENTS-1:0]  elig;
    logic                rearb;
    logic                found;
    logic [ID_W-1:0]     cand;

    // A weight of zero still earns one grant per round.
    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    // Rotate an index by one with wrap-around at CLIENTS.
    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] w);
        return (w == ID_W'(CLIENTS - 1)) ? '0 : w + ID_W'(1);
    endfunction

    // Next-state, credit/pointer update and winner selection.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        credit_d   = credit_q;
        grant_d    = grant;
        grant_id_d = grant_id;
        rearb      = 1'b0;
        elig       = '0;
        found      = 1'b0;
        cand       = '0;

        case (state_q)
            IDLE: begin
                // A stray ack while idle has no effect.
                rearb = |req;
            end
            GRANT: begin
                if (grant_ack) begin
                    // Ack wins over a same-cycle request drop.
                    credit_d[grant_id] = credit_q[grant_id] - WEIGHT_W'(1);
                    ptr_d = (credit_q[grant_id] == WEIGHT_W'(1)) ? next_idx(grant_id) : grant_id;
                    rearb = 1'b1;
                end else if (!req[grant_id]) begin
                    // Withdrawal: no credit spent, priority moves on.
                    ptr_d = next_idx(grant_id);
                    rearb = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rearb) begin
            for (int i = 0; i < CLIENTS; i++) begin
                elig[i] = req[i] && (credit_d[i] != '0);
            end
            // Round exhausted for every requester: start a fresh round now.
            if ((elig == '0) && (req != '0)) begin
                for (int i = 0; i < CLIENTS; i++) begin
                    credit_d[i] = eff_weight(weight_cfg[i*WEIGHT_W +: WEIGHT_W]);
                end
                elig = req;
            end
            // First eligible index at or above ptr, wrapping to the bottom.
            for (int k = 0; k < CLIENTS; k++) begin
                if (int'(ptr_d) + k >= CLIENTS) begin
                    cand = ID_W'(int'(ptr_d) + k - CLIENTS);
                end else begin
                    cand = ID_W'(int'(ptr_d) + k);
                end
                if (!found && elig[cand]) begin
                    found      = 1'b1;
                    grant_id_d = cand;
                end
            end
            if (found) begin
                grant_d = CLIENTS'(1) << grant_id_d;
                state_d = GRANT;
            end else begin
                grant_d    = '0;
                grant_id_d = '0;
                state_d    = IDLE;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Credits, round-robin pointer and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            for (int i = 0; i < CLIENTS; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            grant       <= grant_d;
            grant_valid <= |grant_d;
            grant_id    <= grant_id_d;
            for (int i = 0; i < CLIENTS; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wrr_arb_ack.sv
// Self-checking bench for wrr_arb_ack (CLIENTS=4, WEIGHT_W=4): directed
// scenarios with literal expectations plus a long randomized run compared
// every cycle against a round-based behavioural model.
module tb_wrr_arb_ack;

    localparam int C = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [C-1:0]   req = '0;
    logic [C*W-1:0] weight_cfg = 16'h1111;
    logic           grant_ack = 1'b0;
    logic [C-1:0]   grant;
    logic           grant_valid;
    logic [1:0]     grant_id;

    int errors = 0;
    int checks = 0;

    // Behavioural model: remaining grants this round per client, priority start, current grant.
    int m_cred [C] = '{0, 0, 0, 0};
    int m_ptr  = 0;
    bit m_busy = 0;
    int m_id   = 0;

    wrr_arb_ack #(.CLIENTS(C), .WEIGHT_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .weight_cfg (weight_cfg),
        .grant_ack  (grant_ack),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int weight_of(input int i);
        int w;
        w = int'(weight_cfg[i*W +: W]);
        return (w == 0) ? 1 : w;
    endfunction

    // Choose the next client: any requester with grants left this round, searched
    // upward from the priority start; when none has grants left, begin a new round.
    task automatic m_pick();
        bit any;
        int j;
        any = 0;
        for (int i = 0; i < C; i++) if (req[i] && m_cred[i] > 0) any = 1;
        if (!any && req != 0) for (int i = 0; i < C; i++) m_cred[i] = weight_of(i);
        m_busy = 0;
        m_id   = 0;
        for (int k = C - 1; k >= 0; k--) begin
            j = (m_ptr + k) % C;
            if (req[j] && m_cred[j] > 0) begin
                m_busy = 1;
                m_id   = j;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C; i++) m_cred[i] = 0;
            m_ptr  = 0;
            m_busy = 0;
            m_id   = 0;
        end else if (!m_busy) begin
            if (req != 0) m_pick();
        end else if (grant_ack) begin
            m_cred[m_id] = m_cred[m_id] - 1;
            m_ptr = (m_cred[m_id] == 0) ? (m_id + 1) % C : m_id;
            m_pick();
        end else if (!req[m_id]) begin
            m_ptr = (m_id + 1) % C;
            m_pick();
        end
    end

    always @(negedge clk) begin
        chk("model_grant", grant, m_busy ? (32'd1 << m_id) : 32'd0);
        chk("model_valid", grant_valid, m_busy);
        chk("model_id", grant_id, m_busy ? m_id : 0);
        chk("onehot_inv", ($onehot0(grant) && (grant_valid == |grant)), 1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        grant_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int seq_w [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};

    initial begin
        // Reset state and basic grant
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_valid", grant_valid, 0);
        chk("rst_id", grant_id, 0);
        weight_cfg = 16'h1111;
        do_reset();
        req = 4'b0100;
        step();
        chk("basic_grant", grant, 4'b0100);
        chk("basic_id", grant_id, 2);
        chk("basic_valid", grant_valid, 1);
        step();
        chk("basic_hold", grant, 4'b0100);
        req = 4'b0000;
        grant_ack = 1'b1;
        step();
        chk("basic_idle", grant_valid, 0);
        step();
        chk("stray_ack_idle", grant, 0);
        grant_ack = 1'b0;

        // Weighted sequence, weights 3,1,2,1
        weight_cfg = 16'h1213;
        do_reset();
        req = 4'b1111;
        grant_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("wseq_id", grant_id, seq_w[k]);
            chk("wseq_valid", grant_valid, 1);
        end
        req = '0;
        grant_ack = 1'b0;
        step();

        // Withdrawal keeps client 1's credit, weights 1,2,1,1
        weight_cfg = 16'h1121;
        do_reset();
        req = 4'b0010;
        step();
        chk("wd_first", grant_id, 1);
        req = 4'b1100;
        step();
        chk("wd_moved", grant_id, 2);
        req = 4'b1110;
        grant_ack = 1'b1;
        step();
        chk("wd_next3", grant_id, 3);
        req = 4'b0010;
        step();
        chk("wd_back1", grant_id, 1);
        req = 4'b1010;
        step();
        chk("wd_credit2", grant_id, 1);
        req = '0;
        step();
        chk("wd_idle", grant_valid, 0);
        grant_ack = 1'b0;

        // Wrap-around and zero weight, weights 0,1,1,1
        weight_cfg = 16'h1110;
        do_reset();
        req = 4'b1000;
        step();
        chk("wrap_3", grant_id, 3);
        req = 4'b1001;
        grant_ack = 1'b1;
        step();
        chk("wrap_0", grant_id, 0);
        req = 4'b0001;
        step();
        chk("zw_again0", grant_id, 0);
        req = 4'b1001;
        step();
        chk("zw_once", grant_id, 3);
        req = 4'b0000;
        step();
        chk("wrap_idle_g", grant, 0);
        chk("wrap_idle_id", grant_id, 0);
        chk("wrap_idle_v", grant_valid, 0);
        grant_ack = 1'b0;

        // Ack and request drop in the same cycle count as an ack, weights 2,1,1,1
        weight_cfg = 16'h1112;
        do_reset();
        req = 4'b0011;
        step();
        chk("col_0", grant_id, 0);
        req = 4'b0010;
        grant_ack = 1'b1;
        step();
        chk("col_1", grant_id, 1);
        req = 4'b0011;
        step();
        chk("col_0b", grant_id, 0);
        step();
        chk("col_spent", grant_id, 1);
        req = '0;
        step();
        grant_ack = 1'b0;

        // Reset in the middle of a round, weights 3,1,2,1
        weight_cfg = 16'h1213;
        do_reset();
        req = 4'b1111;
        grant_ack = 1'b1;
        step();
        step();
        step();
        rst_n = 1'b0;
        #2;
        chk("midrst_grant", grant, 0);
        chk("midrst_valid", grant_valid, 0);
        chk("midrst_id", grant_id, 0);
        grant_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_0", grant_id, 0);
        grant_ack = 1'b1;
        step();
        chk("post_rst_1", grant_id, 0);
        step();
        chk("post_rst_2", grant_id, 0);
        step();
        chk("post_rst_3", grant_id, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) weight_cfg = 16'($urandom);
            for (int i = 0; i < C; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            end
            grant_ack = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            step();
        end
        req = '0;
        grant_ack = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
